// File: rtl/stack_pkg.sv
// Shared definitions for the stack-machine instruction sequencer:
// opcodes, FSM states, decoded-instruction record, DSOP bit positions, fault codes.
package stack_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LIT  = 4'h1;
    localparam logic [3:0] OP_DROP = 4'h2;
    localparam logic [3:0] OP_DUP  = 4'h3;
    localparam logic [3:0] OP_ALU  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_JZ   = 4'h6;
    localparam logic [3:0] OP_HALT = 4'h7;

    localparam int DSOP_POP   = 3;
    localparam int DSOP_PUSH  = 2;
    localparam int DSOP_WRITE = 1;
    localparam int DSOP_READ  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_ALU_POP,
        S_ALU_WR,
        S_HALT
    } state_e;

    typedef enum logic [3:0] {
        CL_NOP,
        CL_LIT,
        CL_DROP,
        CL_DUP,
        CL_ALU,
        CL_JMP,
        CL_JZ,
        CL_HALT,
        CL_ILLEGAL
    } op_class_e;

    typedef enum logic [1:0] {
        FAULT_NONE      = 2'b00,
        FAULT_UNDERFLOW = 2'b01,
        FAULT_OVERFLOW  = 2'b10,
        FAULT_ILLEGAL   = 2'b11
    } fault_e;

    typedef struct packed {
        op_class_e   cls;
        logic [2:0]  aluop;
        logic [1:0]  needs_depth;
        logic        pushes;
        logic [11:0] imm;
    } decode_t;

endpackage

// File: rtl/stack_sequencer_if.sv
// Instruction-memory fetch port: request/address out, one-cycle valid/data back.
interface stack_sequencer_if;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_valid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/stack_decoder.sv
// Combinational instruction decode; also reused by the return-stack controller.
module stack_decoder
    import stack_pkg::*;
(
    input  logic [15:0] ir,
    output decode_t     dec
);

    // NOTE: every field gets a default before the case so no path can infer a latch.
    always_comb begin
        dec.cls         = CL_ILLEGAL;
        dec.aluop       = 3'd0;
        dec.needs_depth = 2'd0;
        dec.pushes      = 1'b0;
        dec.imm         = ir[11:0];
        case (ir[15:12])
            OP_NOP:  dec.cls = CL_NOP;
            OP_LIT: begin
                dec.cls    = CL_LIT;
                dec.pushes = 1'b1;
            end
            OP_DROP: begin
                dec.cls         = CL_DROP;
                dec.needs_depth = 2'd1;
            end
            OP_DUP: begin
                dec.cls         = CL_DUP;
                dec.needs_depth = 2'd1;
                dec.pushes      = 1'b1;
            end
            OP_ALU: begin
                dec.cls         = CL_ALU;
                dec.needs_depth = 2'd2;
                dec.aluop       = ir[2:0];
            end
            OP_JMP:  dec.cls = CL_JMP;
            OP_JZ: begin
                dec.cls         = CL_JZ;
                dec.needs_depth = 2'd1;
            end
            OP_HALT: dec.cls = CL_HALT;
            default: ;
        endcase
    end

endmodule

// File: rtl/stack_sequencer.sv
// Fetch/execute sequencer driving the data-stack and data-processor controls,
// with underflow/overflow/illegal-opcode guards that stop execution in HALT.
module stack_sequencer
    import stack_pkg::*;
#(
    parameter logic [11:0] START_ADDR = 12'h000,
    parameter int          DS_DEPTH   = 128
) (
    input  logic               clk,
    input  logic               async_reset,
    input  logic               start,
    stack_sequencer_if.master  imem,
    input  logic [15:0]        sr0_in,
    input  logic [7:0]         ds_size,
    input  logic [15:0]        alu_out,
    output logic [3:0]         DSOP,
    output logic [15:0]        ds_data,
    output logic [2:0]         ALUOP,
    output logic               busy,
    output logic               halted,
    output logic [1:0]         fault
);

    localparam logic [7:0] DEPTH_FULL = 8'(DS_DEPTH);

    state_e      state, state_n;
    logic [11:0] pc, pc_n;
    logic [15:0] ir, ir_n;
    logic [15:0] res, res_n;
    fault_e      fault_q, fault_n;
    decode_t     dec;

    stack_decoder u_decoder (
        .ir  (ir),
        .dec (dec)
    );

    // Reset is synchronous: the name is historical, not a description.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (async_reset) begin
            state   <= S_IDLE;
            pc      <= START_ADDR;
            ir      <= 16'd0;
            res     <= 16'd0;
            fault_q <= FAULT_NONE;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            ir      <= ir_n;
            res     <= res_n;
            fault_q <= fault_n;
        end
    end

    always_comb begin
        state_n        = state;
        pc_n           = pc;
        ir_n           = ir;
        res_n          = res;
        fault_n        = fault_q;
        DSOP           = 4'b0000;
        ds_data        = 16'd0;
        ALUOP          = 3'd0;
        imem.imem_req  = 1'b0;
        imem.imem_addr = 12'd0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_n = S_FETCH;
                    pc_n    = START_ADDR;
                    fault_n = FAULT_NONE;
                end
            end
            S_FETCH: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = pc;
                if (imem.imem_valid) begin
                    ir_n    = imem.imem_rdata;
                    pc_n    = pc + 12'd1;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                state_n = S_FETCH;
                // Guards take priority: a faulting instruction issues no stack op at all.
                if (dec.cls == CL_ILLEGAL) begin
                    fault_n = FAULT_ILLEGAL;
                    state_n = S_HALT;
                end else if (ds_size < {6'd0, dec.needs_depth}) begin
                    fault_n = FAULT_UNDERFLOW;
                    state_n = S_HALT;
                end else if (dec.pushes && ds_size >= DEPTH_FULL) begin
                    fault_n = FAULT_OVERFLOW;
                    state_n = S_HALT;
                end else begin
                    case (dec.cls)
                        CL_LIT: begin
                            DSOP[DSOP_PUSH] = 1'b1;
                            ds_data         = {4'd0, dec.imm};
                        end
                        CL_DUP: begin
                            DSOP[DSOP_PUSH] = 1'b1;
                            ds_data         = sr0_in;
                        end
                        CL_DROP: DSOP[DSOP_POP] = 1'b1;
                        CL_JZ: begin
                            DSOP[DSOP_POP] = 1'b1;
                            if (sr0_in == 16'd0) pc_n = dec.imm;
                        end
                        CL_JMP: pc_n = dec.imm;
                        CL_ALU: begin
                            ALUOP   = dec.aluop;
                            res_n   = alu_out;
                            state_n = S_ALU_POP;
                        end
                        CL_HALT: state_n = S_HALT;
                        default: ;
                    endcase
                end
            end
            S_ALU_POP: begin
                DSOP[DSOP_POP] = 1'b1;
                state_n        = S_ALU_WR;
            end
            S_ALU_WR: begin
                DSOP[DSOP_WRITE] = 1'b1;
                ds_data          = res;
                state_n          = S_FETCH;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);
    assign fault  = fault_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboarded bench: tests queue expected stack operations, a monitor pops and
// compares them whenever DSOP is active; a memory model answers fetches.
module tb_stack_sequencer;

    typedef struct packed {
        logic [3:0]  dsop;
        logic [15:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        async_reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] sr0_in = 16'd0;
    logic [7:0]  ds_size = 8'd0;
    logic [15:0] alu_out = 16'd0;
    logic [3:0]  DSOP;
    logic [15:0] ds_data;
    logic [2:0]  ALUOP;
    logic        busy;
    logic        halted;
    logic [1:0]  fault;

    int          n_tests = 0;
    int          n_fail = 0;
    ev_t         exp_q[$];
    logic [11:0] fetch_log[$];
    logic [15:0] mem [4096];
    int          mem_delay = 0;
    bit          late_valid = 1'b0;

    stack_sequencer_if imem_if ();

    stack_sequencer dut (
        .clk         (clk),
        .async_reset (async_reset),
        .start       (start),
        .imem        (imem_if.master),
        .sr0_in      (sr0_in),
        .ds_size     (ds_size),
        .alu_out     (alu_out),
        .DSOP        (DSOP),
        .ds_data     (ds_data),
        .ALUOP       (ALUOP),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: answers a held request after mem_delay extra cycles.
    initial begin : responder
        int wait_cnt;
        wait_cnt = 0;
        imem_if.imem_valid = 1'b0;
        imem_if.imem_rdata = 16'd0;
        forever begin
            @(negedge clk);
            imem_if.imem_valid = 1'b0;
            if (late_valid) begin
                imem_if.imem_valid = 1'b1;
                imem_if.imem_rdata = 16'h1ABC;
                late_valid = 1'b0;
                wait_cnt = 0;
            end else if (imem_if.imem_req) begin
                if (wait_cnt >= mem_delay) begin
                    imem_if.imem_valid = 1'b1;
                    imem_if.imem_rdata = mem[imem_if.imem_addr];
                    fetch_log.push_back(imem_if.imem_addr);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (DSOP !== 4'b0000) begin
                check("dsop_onehot", 32'($onehot0(DSOP)), 32'd1);
                if (exp_q.size() == 0) begin
                    check("dsop_unexpected", {12'd0, DSOP, ds_data}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("dsop_seq", {12'd0, DSOP, ds_data}, {12'd0, e.dsop, e.data});
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        async_reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        async_reset = 1'b0;
    endtask

    task automatic setup();
        do_reset();
        foreach (mem[i]) mem[i] = 16'h0000;
        fetch_log.delete();
        exp_q.delete();
        mem_delay = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string name, input int budget);
        for (int i = 0; i < budget && !halted; i++) @(negedge clk);
        check({"halt_", name}, 32'(halted), 32'd1);
    endtask

    task automatic expect_op(input logic [3:0] dsop, input logic [15:0] data);
        exp_q.push_back(ev_t'{dsop: dsop, data: data});
    endtask

    initial begin : stimulus
        // Reset state
        setup();
        check("rst_req", 32'(imem_if.imem_req), 32'd0);
        check("rst_addr", 32'(imem_if.imem_addr), 32'd0);
        check("rst_dsop", 32'(DSOP), 32'd0);
        check("rst_ds_data", 32'(ds_data), 32'd0);
        check("rst_aluop", 32'(ALUOP), 32'd0);
        check("rst_busy_halted", {30'd0, busy, halted}, 32'd0);
        check("rst_fault", 32'(fault), 32'd0);

        // LIT 5; LIT 3; ALU 0; HALT
        setup();
        mem[0] = 16'h1005; mem[1] = 16'h1003; mem[2] = 16'h4000; mem[3] = 16'h7000;
        ds_size = 8'd2;
        alu_out = 16'h0008;
        expect_op(4'b0100, 16'h0005);
        expect_op(4'b0100, 16'h0003);
        expect_op(4'b1000, 16'h0000);
        expect_op(4'b0010, 16'h0008);
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        wait_halt("prog1", 100);
        check("prog1_fault", 32'(fault), 32'd0);
        check("prog1_busy", 32'(busy), 32'd0);
        check("prog1_drained", 32'(exp_q.size()), 32'd0);

        // Slow memory: request and address held while waiting
        setup();
        mem_delay = 4;
        mem[0] = 16'h0000; mem[1] = 16'h7000;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            check("wait_req", 32'(imem_if.imem_req), 32'd1);
            check("wait_addr", 32'(imem_if.imem_addr), 32'd0);
            check("wait_dsop", 32'(DSOP), 32'd0);
            @(negedge clk);
        end
        wait_halt("slow", 100);
        check("slow_fetches", 32'(fetch_log.size()), 32'd2);
        check("slow_second_addr", 32'(fetch_log[1]), 32'h001);

        // JZ taken
        setup();
        mem[0] = 16'h6020; mem[12'h020] = 16'h7000; mem[1] = 16'h7000;
        ds_size = 8'd1;
        sr0_in = 16'd0;
        expect_op(4'b1000, 16'h0000);
        pulse_start();
        wait_halt("jz_taken", 50);
        check("jz_taken_addr", 32'(fetch_log[1]), 32'h020);
        check("jz_taken_drained", 32'(exp_q.size()), 32'd0);

        // JZ not taken
        setup();
        mem[0] = 16'h6020; mem[12'h020] = 16'h7000; mem[1] = 16'h7000;
        sr0_in = 16'd7;
        expect_op(4'b1000, 16'h0000);
        pulse_start();
        wait_halt("jz_not_taken", 50);
        check("jz_not_taken_addr", 32'(fetch_log[1]), 32'h001);
        check("jz_not_taken_drained", 32'(exp_q.size()), 32'd0);

        // DROP on an empty stack
        setup();
        mem[0] = 16'h2000;
        ds_size = 8'd0;
        pulse_start();
        wait_halt("underflow", 50);
        check("underflow_fault", 32'(fault), 32'h1);

        // LIT on a full stack, then restart clears the fault
        setup();
        mem[0] = 16'h1001;
        ds_size = 8'd128;
        pulse_start();
        wait_halt("overflow", 50);
        check("overflow_fault", 32'(fault), 32'h2);
        pulse_start();
        check("restart_fault_clear", 32'(fault), 32'd0);
        check("restart_addr", 32'(imem_if.imem_addr), 32'd0);

        // Illegal opcode
        setup();
        mem[0] = 16'hF000;
        ds_size = 8'd4;
        pulse_start();
        wait_halt("illegal", 50);
        check("illegal_fault", 32'(fault), 32'h3);

        // PC wrap: JMP 0xFFF; NOP at 0xFFF; next fetch from 0x000
        setup();
        mem[0] = 16'h5FFF; mem[12'hFFF] = 16'h0000;
        pulse_start();
        for (int i = 0; i < 20 && fetch_log.size() < 1; i++) @(negedge clk);
        mem[0] = 16'h7000;
        wait_halt("wrap", 50);
        check("wrap_fetches", 32'(fetch_log.size()), 32'd3);
        check("wrap_jmp_addr", 32'(fetch_log[1]), 32'hFFF);
        check("wrap_addr", 32'(fetch_log[2]), 32'h000);

        // Reset during ALU_POP, late valid in IDLE, restart
        setup();
        mem[0] = 16'h4002;
        ds_size = 8'd2;
        alu_out = 16'h1234;
        expect_op(4'b1000, 16'h0000);
        pulse_start();
        for (int i = 0; i < 20 && ALUOP == 3'd0; i++) @(negedge clk);
        check("alu_sel", 32'(ALUOP), 32'd2);
        @(negedge clk);
        check("alu_pop_dsop", 32'(DSOP), 32'b1000);
        async_reset = 1'b1;
        @(negedge clk);
        check("mid_rst_req", 32'(imem_if.imem_req), 32'd0);
        check("mid_rst_dsop", 32'(DSOP), 32'd0);
        check("mid_rst_data", 32'(ds_data), 32'd0);
        check("mid_rst_busy_halted", {30'd0, busy, halted}, 32'd0);
        async_reset = 1'b0;
        late_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("late_valid_busy", 32'(busy), 32'd0);
        check("late_valid_req", 32'(imem_if.imem_req), 32'd0);
        check("mid_rst_drained", 32'(exp_q.size()), 32'd0);
        mem[0] = 16'h7000;
        fetch_log.delete();
        pulse_start();
        wait_halt("resume", 50);
        check("resume_addr", 32'(fetch_log[0]), 32'h000);
        check("resume_fault", 32'(fault), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
